// File: rtl/spike_input_arbiter.sv
// Round-robin arbiter that funnels NUM_PORTS spike requesters into one registered
// output port, with per-port grant counters, starvation flags and a 32-bit config bus.
module spike_input_arbiter #(
   parameter int NUM_PORTS       = 4,
   parameter int PORT_ID_WIDTH   = 2,
   parameter int NEURON_ID_WIDTH = 6,
   parameter int STARVE_LIMIT    = 64
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_PORTS-1:0]                 s_spike_valid,
   input  logic [NUM_PORTS*NEURON_ID_WIDTH-1:0] s_spike_neuron_id,
   output logic [NUM_PORTS-1:0]                 s_spike_ready,
   output logic                                 m_spike_valid,
   output logic [NEURON_ID_WIDTH-1:0]           m_spike_neuron_id,
   output logic [PORT_ID_WIDTH-1:0]             m_spike_src_port,
   input  logic                                 m_spike_ready,
   input  logic                                 config_we,
   input  logic [7:0]                           config_addr,
   input  logic [31:0]                          config_data,
   output logic [31:0]                          config_readdata,
   output logic                                 starve_any,
   output logic                                 arb_busy
);

   localparam logic [15:0]              LIMIT     = 16'(STARVE_LIMIT);
   localparam logic [PORT_ID_WIDTH-1:0] LAST_PORT = PORT_ID_WIDTH'(NUM_PORTS - 1);

   logic                       m_valid_q, m_valid_d;
   logic [NEURON_ID_WIDTH-1:0] m_id_q, m_id_d;
   logic [PORT_ID_WIDTH-1:0]   m_src_q, m_src_d;
   logic [PORT_ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NUM_PORTS-1:0]       enable_mask_q, enable_mask_d;
   logic [NUM_PORTS-1:0]       starve_flag_q, starve_flag_d;
   logic [31:0]                grant_count_q [NUM_PORTS];
   logic [31:0]                grant_count_d [NUM_PORTS];
   logic [15:0]                wait_cnt_q [NUM_PORTS];
   logic [15:0]                wait_cnt_d [NUM_PORTS];

   logic [NUM_PORTS-1:0]       eligible;
   logic                       load;
   logic                       accept;
   logic                       grant_found;
   logic [PORT_ID_WIDTH-1:0]   grant_idx;
   logic [NEURON_ID_WIDTH-1:0] grant_id;
   logic                       clr_counts;
   logic                       clr_starve;
   logic                       write_mask;
   logic                       unused_cfg_bits;

   assign eligible   = s_spike_valid & enable_mask_q;
   assign load       = !m_valid_q || m_spike_ready;
   assign accept     = load && grant_found;
   assign write_mask = config_we && (config_addr == 8'h00);
   assign clr_counts = config_we && (config_addr == 8'h01) && config_data[0];
   assign clr_starve = config_we && (config_addr == 8'h01) && config_data[1];
   assign unused_cfg_bits = ^config_data[31:NUM_PORTS];

   // Two-pass priority scan: ports at or above rr_ptr first, then wrap to the lowest.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!grant_found && eligible[i] && (PORT_ID_WIDTH'(i) >= rr_ptr_q)) begin
            grant_found = 1'b1;
            grant_idx   = PORT_ID_WIDTH'(i);
         end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!grant_found && eligible[i]) begin
            grant_found = 1'b1;
            grant_idx   = PORT_ID_WIDTH'(i);
         end
      end
   end

   always_comb begin
      grant_id      = '0;
      s_spike_ready = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_idx == PORT_ID_WIDTH'(i)) begin
            grant_id         = s_spike_neuron_id[i*NEURON_ID_WIDTH +: NEURON_ID_WIDTH];
            s_spike_ready[i] = !rst && accept;
         end
      end
   end

   always_comb begin
      m_valid_d     = m_valid_q;
      m_id_d        = m_id_q;
      m_src_d       = m_src_q;
      rr_ptr_d      = rr_ptr_q;
      enable_mask_d = write_mask ? config_data[NUM_PORTS-1:0] : enable_mask_q;
      if (load) begin
         m_valid_d = grant_found;
         if (grant_found) begin
            m_id_d   = grant_id;
            m_src_d  = grant_idx;
            rr_ptr_d = (grant_idx == LAST_PORT) ? '0 : grant_idx + PORT_ID_WIDTH'(1);
         end
      end
   end

   // Clears from the config bus override same-cycle increments and flag sets.
   always_comb begin
      starve_flag_d = starve_flag_q;
      for (int i = 0; i < NUM_PORTS; i++) begin
         grant_count_d[i] = grant_count_q[i];
         wait_cnt_d[i]    = '0;
         if (accept && (grant_idx == PORT_ID_WIDTH'(i))) begin
            grant_count_d[i] = grant_count_q[i] + 32'd1;
         end else if (eligible[i]) begin
            wait_cnt_d[i] = (wait_cnt_q[i] == LIMIT) ? LIMIT : wait_cnt_q[i] + 16'd1;
         end
         if (wait_cnt_d[i] == LIMIT) begin
            starve_flag_d[i] = 1'b1;
         end
         if (clr_counts) begin
            grant_count_d[i] = '0;
         end
         if (clr_starve) begin
            wait_cnt_d[i]    = '0;
            starve_flag_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid_q     <= 1'b0;
         m_id_q        <= '0;
         m_src_q       <= '0;
         rr_ptr_q      <= '0;
         enable_mask_q <= '1;
         starve_flag_q <= '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            grant_count_q[i] <= '0;
            wait_cnt_q[i]    <= '0;
         end
      end else begin
         m_valid_q     <= m_valid_d;
         m_id_q        <= m_id_d;
         m_src_q       <= m_src_d;
         rr_ptr_q      <= rr_ptr_d;
         enable_mask_q <= enable_mask_d;
         starve_flag_q <= starve_flag_d;
         for (int i = 0; i < NUM_PORTS; i++) begin
            grant_count_q[i] <= grant_count_d[i];
            wait_cnt_q[i]    <= wait_cnt_d[i];
         end
      end
   end

   always_comb begin
      config_readdata = 32'hDEADBEEF;
      case (config_addr)
         8'h00:   config_readdata = {{(32-NUM_PORTS){1'b0}}, enable_mask_q};
         8'h02:   config_readdata = {{(32-PORT_ID_WIDTH){1'b0}}, rr_ptr_q};
         8'h20:   config_readdata = {{(32-NUM_PORTS){1'b0}}, starve_flag_q};
         default: begin
            for (int i = 0; i < NUM_PORTS; i++) begin
               if (config_addr == 8'(16 + i)) begin
                  config_readdata = grant_count_q[i];
               end
            end
         end
      endcase
   end

   assign m_spike_valid     = m_valid_q;
   assign m_spike_neuron_id = m_id_q;
   assign m_spike_src_port  = m_src_q;
   assign starve_any        = |starve_flag_q;
   assign arb_busy          = m_valid_q || (|eligible);

endmodule

// File: tb/tb_spike_input_arbiter.sv
// Self-checking bench for spike_input_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural reference model.
module tb_spike_input_arbiter;

   localparam int N   = 4;
   localparam int PW  = 2;
   localparam int W   = 6;
   localparam int LIM = 64;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   s_spike_valid;
   logic [N*W-1:0] s_spike_neuron_id;
   logic [N-1:0]   s_spike_ready;
   logic           m_spike_valid;
   logic [W-1:0]   m_spike_neuron_id;
   logic [PW-1:0]  m_spike_src_port;
   logic           m_spike_ready;
   logic           config_we;
   logic [7:0]     config_addr;
   logic [31:0]    config_data;
   logic [31:0]    config_readdata;
   logic           starve_any;
   logic           arb_busy;

   always #5 clk = ~clk;

   spike_input_arbiter #(
      .NUM_PORTS(N), .PORT_ID_WIDTH(PW), .NEURON_ID_WIDTH(W), .STARVE_LIMIT(LIM)
   ) dut (
      .clk(clk), .rst(rst),
      .s_spike_valid(s_spike_valid), .s_spike_neuron_id(s_spike_neuron_id),
      .s_spike_ready(s_spike_ready),
      .m_spike_valid(m_spike_valid), .m_spike_neuron_id(m_spike_neuron_id),
      .m_spike_src_port(m_spike_src_port), .m_spike_ready(m_spike_ready),
      .config_we(config_we), .config_addr(config_addr), .config_data(config_data),
      .config_readdata(config_readdata),
      .starve_any(starve_any), .arb_busy(arb_busy)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   bit          md_valid;
   logic [W-1:0] md_id;
   int          md_src;
   int          md_ptr;
   logic [N-1:0] md_mask;
   logic [31:0] md_cnt [N];
   int          md_wait [N];
   logic [N-1:0] md_flag;

   localparam logic [N*W-1:0] IDS4 = {6'd4, 6'd3, 6'd2, 6'd1};

   typedef struct {
      bit          r;
      logic [3:0]  v;
      logic [23:0] ids;
      logic [7:0]  a;
      logic [3:0]  e_ready;
      bit          e_mv;
      logic [5:0]  e_id;
      logic [1:0]  e_src;
      logic [31:0] e_rd;
   } vec_t;

   vec_t tbl [15];

   task automatic modelReset();
      md_valid = 1'b0;
      md_id    = '0;
      md_src   = 0;
      md_ptr   = 0;
      md_mask  = '1;
      md_flag  = '0;
      for (int i = 0; i < N; i++) begin
         md_cnt[i]  = 0;
         md_wait[i] = 0;
      end
   endtask

   function automatic int modelGrant();
      for (int k = 0; k < N; k++) begin
         int p;
         p = (md_ptr + k) % N;
         if (s_spike_valid[p] && md_mask[p]) return p;
      end
      return -1;
   endfunction

   function automatic logic [31:0] modelRead(input logic [7:0] a);
      int ai;
      ai = int'(a);
      if (ai == 0) return {28'b0, md_mask};
      if (ai == 2) return 32'(md_ptr);
      if (ai == 32) return {28'b0, md_flag};
      if (ai >= 16 && ai < 16 + N) return md_cnt[ai - 16];
      return 32'hDEADBEEF;
   endfunction

   task automatic modelUpdate();
      int g;
      bit ld;
      bit acc;
      if (rst) begin
         modelReset();
         return;
      end
      g   = modelGrant();
      ld  = !md_valid || m_spike_ready;
      acc = ld && (g >= 0);
      for (int i = 0; i < N; i++) begin
         if (s_spike_valid[i] && md_mask[i] && !(acc && g == i))
            md_wait[i] = (md_wait[i] + 1 > LIM) ? LIM : md_wait[i] + 1;
         else
            md_wait[i] = 0;
         if (md_wait[i] == LIM) md_flag[i] = 1'b1;
      end
      if (ld) begin
         md_valid = acc;
         if (acc) begin
            md_id     = s_spike_neuron_id[g*W +: W];
            md_src    = g;
            md_ptr    = (g + 1) % N;
            md_cnt[g] = md_cnt[g] + 1;
         end
      end
      if (config_we && config_addr == 8'h00) md_mask = config_data[N-1:0];
      if (config_we && config_addr == 8'h01) begin
         if (config_data[0]) for (int i = 0; i < N; i++) md_cnt[i] = 0;
         if (config_data[1]) begin
            md_flag = '0;
            for (int i = 0; i < N; i++) md_wait[i] = 0;
         end
      end
   endtask

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic checkOutput();
      int g;
      logic [N-1:0] er;
      g  = modelGrant();
      er = '0;
      if (!rst && (!md_valid || m_spike_ready) && g >= 0) er[g] = 1'b1;
      checkVal("s_spike_ready", 32'(s_spike_ready), 32'(er));
      checkVal("m_spike_valid", 32'(m_spike_valid), 32'(md_valid));
      checkVal("m_spike_neuron_id", 32'(m_spike_neuron_id), 32'(md_id));
      checkVal("m_spike_src_port", 32'(m_spike_src_port), 32'(md_src));
      checkVal("config_readdata", config_readdata, modelRead(config_addr));
      checkVal("starve_any", 32'(starve_any), 32'(|md_flag));
      checkVal("arb_busy", 32'(arb_busy), 32'(md_valid || (|(s_spike_valid & md_mask))));
   endtask

   task automatic applyStimulus(input bit r, input logic [N-1:0] v, input logic [N*W-1:0] ids,
                                input bit mr, input bit we, input logic [7:0] a,
                                input logic [31:0] d);
      rst               = r;
      s_spike_valid     = v;
      s_spike_neuron_id = ids;
      m_spike_ready     = mr;
      config_we         = we;
      config_addr       = a;
      config_data       = d;
      #3;
   endtask

   task automatic tick();
      @(posedge clk);
      modelUpdate();
      #1;
   endtask

   task automatic cycle(input bit r, input logic [N-1:0] v, input logic [N*W-1:0] ids,
                        input bit mr, input bit we, input logic [7:0] a, input logic [31:0] d);
      applyStimulus(r, v, ids, mr, we, a, d);
      checkOutput();
      tick();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      tbl[0]  = '{1'b1, 4'h0, 24'h0,    8'h00, 4'h0, 1'b0, 6'h00, 2'd0, 32'h0000000F};
      tbl[1]  = '{1'b0, 4'h4, 24'h015000, 8'h12, 4'h4, 1'b0, 6'h00, 2'd0, 32'h0};
      tbl[2]  = '{1'b0, 4'h0, 24'h015000, 8'h12, 4'h0, 1'b1, 6'h15, 2'd2, 32'h1};
      tbl[3]  = '{1'b0, 4'h0, 24'h0,    8'h02, 4'h0, 1'b0, 6'h15, 2'd2, 32'h3};
      tbl[4]  = '{1'b1, 4'h0, 24'h0,    8'h02, 4'h0, 1'b0, 6'h15, 2'd2, 32'h3};
      tbl[5]  = '{1'b0, 4'hF, IDS4,     8'h7F, 4'h1, 1'b0, 6'h00, 2'd0, 32'hDEADBEEF};
      tbl[6]  = '{1'b0, 4'hF, IDS4,     8'h7F, 4'h2, 1'b1, 6'h01, 2'd0, 32'hDEADBEEF};
      tbl[7]  = '{1'b0, 4'hF, IDS4,     8'h7F, 4'h4, 1'b1, 6'h02, 2'd1, 32'hDEADBEEF};
      tbl[8]  = '{1'b0, 4'hF, IDS4,     8'h7F, 4'h8, 1'b1, 6'h03, 2'd2, 32'hDEADBEEF};
      tbl[9]  = '{1'b0, 4'hF, IDS4,     8'h7F, 4'h1, 1'b1, 6'h04, 2'd3, 32'hDEADBEEF};
      tbl[10] = '{1'b0, 4'hF, IDS4,     8'h7F, 4'h2, 1'b1, 6'h01, 2'd0, 32'hDEADBEEF};
      tbl[11] = '{1'b0, 4'hF, IDS4,     8'h7F, 4'h4, 1'b1, 6'h02, 2'd1, 32'hDEADBEEF};
      tbl[12] = '{1'b0, 4'hF, IDS4,     8'h7F, 4'h8, 1'b1, 6'h03, 2'd2, 32'hDEADBEEF};
      tbl[13] = '{1'b0, 4'h0, IDS4,     8'h10, 4'h0, 1'b1, 6'h04, 2'd3, 32'h2};
      tbl[14] = '{1'b0, 4'h0, IDS4,     8'h13, 4'h0, 1'b0, 6'h04, 2'd3, 32'h2};

      rst = 1'b1; s_spike_valid = '0; s_spike_neuron_id = '0; m_spike_ready = 1'b1;
      config_we = 1'b0; config_addr = '0; config_data = '0;
      repeat (2) @(posedge clk);
      modelReset();
      #1;

      // Directed vector table: single-port grant, reset, then full round-robin
      foreach (tbl[k]) begin
         applyStimulus(tbl[k].r, tbl[k].v, tbl[k].ids, 1'b1, 1'b0, tbl[k].a, 32'h0);
         checkOutput();
         checkVal($sformatf("tbl%0d_ready", k), 32'(s_spike_ready), 32'(tbl[k].e_ready));
         checkVal($sformatf("tbl%0d_mvalid", k), 32'(m_spike_valid), 32'(tbl[k].e_mv));
         checkVal($sformatf("tbl%0d_id", k), 32'(m_spike_neuron_id), 32'(tbl[k].e_id));
         checkVal($sformatf("tbl%0d_src", k), 32'(m_spike_src_port), 32'(tbl[k].e_src));
         checkVal($sformatf("tbl%0d_rd", k), config_readdata, tbl[k].e_rd);
         tick();
      end

      // Stall: hold a port-1 spike for 5 cycles, then the next grant goes to port 2
      cycle(1'b0, 4'b0010, IDS4, 1'b1, 1'b0, 8'h02, 32'h0);
      for (int j = 0; j < 5; j++) begin
         applyStimulus(1'b0, 4'hF, IDS4, 1'b0, 1'b0, 8'h02, 32'h0);
         checkOutput();
         checkVal("stall_ready", 32'(s_spike_ready), 32'h0);
         checkVal("stall_src", 32'(m_spike_src_port), 32'd1);
         checkVal("stall_id", 32'(m_spike_neuron_id), 32'd2);
         tick();
      end
      applyStimulus(1'b0, 4'hF, IDS4, 1'b1, 1'b0, 8'h02, 32'h0);
      checkOutput();
      checkVal("resume_grant", 32'(s_spike_ready), 32'h4);
      tick();

      // Masked port never granted and never starves; re-enabled and blocked, it starves
      cycle(1'b0, 4'b0000, IDS4, 1'b1, 1'b1, 8'h00, 32'hE);
      for (int j = 0; j < 100; j++) cycle(1'b0, 4'b0001, IDS4, 1'b1, 1'b0, 8'h10, 32'h0);
      applyStimulus(1'b0, 4'b0001, IDS4, 1'b1, 1'b0, 8'h20, 32'h0);
      checkOutput();
      checkVal("masked_ready", 32'(s_spike_ready), 32'h0);
      checkVal("masked_flag", config_readdata, 32'h0);
      tick();
      cycle(1'b0, 4'b0010, IDS4, 1'b1, 1'b1, 8'h00, 32'hF);
      for (int j = 0; j < LIM; j++) cycle(1'b0, 4'b0001, IDS4, 1'b0, 1'b0, 8'h20, 32'h0);
      applyStimulus(1'b0, 4'b0001, IDS4, 1'b0, 1'b0, 8'h20, 32'h0);
      checkOutput();
      checkVal("starve_flag0", config_readdata, 32'h1);
      checkVal("starve_any_set", 32'(starve_any), 32'h1);
      tick();

      // Clear collides with a port-1 accept: the clear wins
      cycle(1'b0, 4'b0010, IDS4, 1'b1, 1'b1, 8'h01, 32'h3);
      applyStimulus(1'b0, 4'b0000, IDS4, 1'b0, 1'b0, 8'h11, 32'h0);
      checkOutput();
      checkVal("clr_count1", config_readdata, 32'h0);
      checkVal("clr_starve_any", 32'(starve_any), 32'h0);
      checkVal("clr_held_valid", 32'(m_spike_valid), 32'h1);
      tick();

      // Reset while a spike is held
      applyStimulus(1'b1, 4'hF, IDS4, 1'b0, 1'b0, 8'h02, 32'h0);
      checkOutput();
      checkVal("rst_ready", 32'(s_spike_ready), 32'h0);
      tick();
      applyStimulus(1'b0, 4'h0, IDS4, 1'b0, 1'b0, 8'h02, 32'h0);
      checkOutput();
      checkVal("rst_mvalid", 32'(m_spike_valid), 32'h0);
      checkVal("rst_ptr", config_readdata, 32'h0);
      tick();

      // Randomized traffic with periodic long output stalls
      for (int j = 0; j < 600; j++) begin
         logic [7:0]  a;
         logic [31:0] d;
         bit          we;
         bit          mr;
         int          pick;
         pick = $urandom_range(0, 9);
         case (pick)
            0: a = 8'h00;
            1: a = 8'h02;
            2, 3: a = 8'(16 + $urandom_range(0, N - 1));
            4: a = 8'h20;
            5: a = 8'h7F;
            6: a = 8'($urandom);
            default: a = 8'h01;
         endcase
         we = ($urandom_range(0, 24) == 0);
         if (we && $urandom_range(0, 1) == 0) a = 8'h00;
         d  = $urandom;
         if (a == 8'h00 && $urandom_range(0, 2) != 0) d = d | 32'hF;
         if (a == 8'h01 && $urandom_range(0, 3) != 0) d = d & 32'hFFFF_FFFC;
         mr = ((j / 80) % 3 == 1) ? 1'b0 : ($urandom_range(0, 9) < 7);
         cycle(($urandom_range(0, 249) == 0), 4'($urandom), 24'($urandom), mr, we, a, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
